// File: rtl/xdma_finish_tracker.sv
// Outstanding chain-write hop tracker: matches from-remote finish tokens to first/middle hop slots
// and queues completions to the frontend and the previous hop. Optional: XDMA_FINISH_TIMEOUT_EN.
module xdma_finish_tracker #(
   parameter int IdWidth    = 8,
   parameter int AddrWidth  = 48,
   parameter int NumSlots   = 4,
   parameter int SendDepth  = 4,
   parameter int TimeoutCyc = 4096
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_valid_i,
   output logic                          start_ready_o,
   input  logic                          start_is_middle_i,
   input  logic [IdWidth-1:0]            start_id_i,
   input  logic [AddrWidth-1:0]          start_addr_i,
   input  logic                          last_done_valid_i,
   output logic                          last_done_ready_o,
   input  logic [IdWidth-1:0]            last_done_id_i,
   input  logic [AddrWidth-1:0]          last_done_addr_i,
   input  logic                          read_done_valid_i,
   output logic                          read_done_ready_o,
   input  logic [IdWidth-1:0]            read_done_id_i,
   input  logic                          from_remote_finish_valid_i,
   output logic                          from_remote_finish_ready_o,
   input  logic [IdWidth-1:0]            from_remote_finish_id_i,
   output logic                          xdma_finish_o,
   input  logic                          xdma_finish_ready_i,
   output logic [IdWidth-1:0]            xdma_finish_id_o,
   output logic                          xdma_finish_is_read_o,
   output logic                          xdma_write_finish_o,
   output logic                          to_remote_finish_valid_o,
   input  logic                          to_remote_finish_ready_i,
   output logic [IdWidth-1:0]            from_remote_dma_id_o,
   output logic [AddrWidth-1:0]          remote_addr_o,
   output logic [$clog2(NumSlots+1)-1:0] outstanding_o,
   output logic                          unmatched_o
);
   localparam int CntW  = $clog2(NumSlots+1);
   localparam int SIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
   localparam int PtrW  = (SendDepth > 1) ? $clog2(SendDepth) : 1;
   localparam int FcW   = $clog2(SendDepth+1);

   logic [NumSlots-1:0]                slot_vld_q, slot_vld_d, slot_mid_q;
   logic [NumSlots-1:0][IdWidth-1:0]   slot_id_q;
   logic [NumSlots-1:0][AddrWidth-1:0] slot_addr_q;

   logic                 lf_vld_q, lf_rd_q;
   logic [IdWidth-1:0]   lf_id_q;
   logic [SendDepth-1:0][IdWidth-1:0]   sq_id_q;
   logic [SendDepth-1:0][AddrWidth-1:0] sq_addr_q;
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [FcW-1:0]       sq_cnt_q;
   logic                 wf_q, unm_q;

   logic [NumSlots-1:0]  hit_vec, free_mask, alloc_mask;
   logic                 hit_any, hit_mid, free_any, dup_any;
   logic [AddrWidth-1:0] hit_addr;
   logic [SIdxW-1:0]     free_idx;
   logic                 sq_full, tok_first_acc, tok_mid_acc;
   logic                 to_first, to_mid;
   logic [SIdxW-1:0]     to_sel;
   logic                 first_ld, mid_push, rd_acc, ld_acc, alloc, sq_pop, sq_push;
   logic [IdWidth-1:0]   push_id;
   logic [AddrWidth-1:0] push_addr;

   always_comb begin
      hit_vec  = '0;
      hit_mid  = 1'b0;
      hit_addr = '0;
      free_any = 1'b0;
      free_idx = '0;
      dup_any  = 1'b0;
      for (int i = NumSlots-1; i >= 0; i--) begin
         hit_vec[i] = slot_vld_q[i] && (slot_id_q[i] == from_remote_finish_id_i);
         if (hit_vec[i]) begin
            hit_mid  = slot_mid_q[i];
            hit_addr = slot_addr_q[i];
         end
         if (!slot_vld_q[i]) begin
            free_any = 1'b1;
            free_idx = SIdxW'(i);
         end
         if (slot_vld_q[i] && slot_id_q[i] == start_id_i) dup_any = 1'b1;
      end
   end

   assign hit_any       = |hit_vec;
   assign sq_full       = (sq_cnt_q == FcW'(SendDepth));
   assign tok_first_acc = from_remote_finish_valid_i && hit_any && !hit_mid && !lf_vld_q;
   assign tok_mid_acc   = from_remote_finish_valid_i && hit_any && hit_mid && !sq_full;
   assign from_remote_finish_ready_o = !hit_any || (hit_mid ? !sq_full : !lf_vld_q);

`ifdef XDMA_FINISH_TIMEOUT_EN
   localparam int TcW = $clog2(TimeoutCyc+1);
   logic [NumSlots-1:0][TcW-1:0] tmo_q;
   logic [NumSlots-1:0]          exp_vec;
   logic                         exp_any;

   // A slot the token is freeing this cycle is not also forced out.
   always_comb begin
      exp_any = 1'b0;
      to_sel  = '0;
      for (int i = NumSlots-1; i >= 0; i--) begin
         exp_vec[i] = slot_vld_q[i] && (tmo_q[i] == TcW'(TimeoutCyc)) &&
                      !(hit_vec[i] && (tok_first_acc || tok_mid_acc));
         if (exp_vec[i]) begin
            exp_any = 1'b1;
            to_sel  = SIdxW'(i);
         end
      end
   end

   assign to_first = exp_any && !slot_mid_q[to_sel] && !lf_vld_q && !tok_first_acc;
   assign to_mid   = exp_any && slot_mid_q[to_sel] && !sq_full && !tok_mid_acc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else begin
         for (int i = 0; i < NumSlots; i++) begin
            if (alloc_mask[i])                                       tmo_q[i] <= '0;
            else if (slot_vld_q[i] && tmo_q[i] != TcW'(TimeoutCyc)) tmo_q[i] <= tmo_q[i] + TcW'(1);
         end
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TimeoutCyc > 0);
   assign to_first   = 1'b0;
   assign to_mid     = 1'b0;
   assign to_sel     = '0;
`endif

   assign first_ld          = tok_first_acc || to_first;
   assign mid_push          = tok_mid_acc || to_mid;
   assign read_done_ready_o = !lf_vld_q && !first_ld;
   assign rd_acc            = read_done_valid_i && read_done_ready_o;
   assign last_done_ready_o = !sq_full && !mid_push;
   assign ld_acc            = last_done_valid_i && last_done_ready_o;
   assign start_ready_o     = free_any && !dup_any;
   assign alloc             = start_valid_i && start_ready_o;
   assign sq_pop            = (sq_cnt_q != '0) && to_remote_finish_ready_i;
   assign sq_push           = mid_push || ld_acc;

   always_comb begin
      push_id   = last_done_id_i;
      push_addr = last_done_addr_i;
      if (tok_mid_acc) begin
         push_id   = from_remote_finish_id_i;
         push_addr = hit_addr;
      end else if (to_mid) begin
         push_id   = slot_id_q[to_sel];
         push_addr = slot_addr_q[to_sel];
      end
      free_mask  = '0;
      alloc_mask = '0;
      if (tok_first_acc || tok_mid_acc) free_mask = hit_vec;
      if (to_first || to_mid)           free_mask[to_sel] = 1'b1;
      if (alloc)                        alloc_mask[free_idx] = 1'b1;
      slot_vld_d = (slot_vld_q & ~free_mask) | alloc_mask;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_vld_q  <= '0;
         slot_mid_q  <= '0;
         slot_id_q   <= '0;
         slot_addr_q <= '0;
      end else begin
         slot_vld_q <= slot_vld_d;
         if (alloc) begin
            slot_mid_q[free_idx]  <= start_is_middle_i;
            slot_id_q[free_idx]   <= start_id_i;
            slot_addr_q[free_idx] <= start_addr_i;
         end
      end
   end

   // Loads only happen into an empty register, so load and pop never collide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lf_vld_q <= 1'b0;
         lf_rd_q  <= 1'b0;
         lf_id_q  <= '0;
      end else if (first_ld) begin
         lf_vld_q <= 1'b1;
         lf_rd_q  <= 1'b0;
         lf_id_q  <= tok_first_acc ? from_remote_finish_id_i : slot_id_q[to_sel];
      end else if (rd_acc) begin
         lf_vld_q <= 1'b1;
         lf_rd_q  <= 1'b1;
         lf_id_q  <= read_done_id_i;
      end else if (lf_vld_q && xdma_finish_ready_i) begin
         lf_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sq_id_q   <= '0;
         sq_addr_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         sq_cnt_q  <= '0;
         wf_q      <= 1'b0;
         unm_q     <= 1'b0;
      end else begin
         if (sq_push) begin
            sq_id_q[wr_ptr_q]   <= push_id;
            sq_addr_q[wr_ptr_q] <= push_addr;
            wr_ptr_q <= (wr_ptr_q == PtrW'(SendDepth-1)) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (sq_pop) rd_ptr_q <= (rd_ptr_q == PtrW'(SendDepth-1)) ? '0 : rd_ptr_q + PtrW'(1);
         if (sq_push && !sq_pop)      sq_cnt_q <= sq_cnt_q + FcW'(1);
         else if (!sq_push && sq_pop) sq_cnt_q <= sq_cnt_q - FcW'(1);
         wf_q  <= first_ld || sq_pop;
         unm_q <= from_remote_finish_valid_i && !hit_any;
      end
   end

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < NumSlots; i++) outstanding_o = outstanding_o + CntW'(slot_vld_q[i]);
   end

   assign xdma_finish_o            = lf_vld_q;
   assign xdma_finish_id_o         = lf_id_q;
   assign xdma_finish_is_read_o    = lf_rd_q;
   assign xdma_write_finish_o      = wf_q;
   assign to_remote_finish_valid_o = (sq_cnt_q != '0);
   assign from_remote_dma_id_o     = sq_id_q[rd_ptr_q];
   assign remote_addr_o            = sq_addr_q[rd_ptr_q];
   assign unmatched_o              = unm_q;
endmodule

// File: tb/tb_xdma_finish_tracker.sv
// Random-stimulus bench for xdma_finish_tracker against a map/queue reference model.
module tb_xdma_finish_tracker;
   logic        clk = 0, rst_ni = 0;
   logic        start_valid, start_ready, start_is_middle;
   logic [7:0]  start_id;
   logic [47:0] start_addr;
   logic        ld_valid, ld_ready;
   logic [7:0]  ld_id;
   logic [47:0] ld_addr;
   logic        rd_valid, rd_ready;
   logic [7:0]  rd_id;
   logic        fr_valid, fr_ready;
   logic [7:0]  fr_id;
   logic        xf, xf_ready, xf_is_read, wf;
   logic [7:0]  xf_id;
   logic        tr_valid, tr_ready;
   logic [7:0]  tr_id;
   logic [47:0] tr_addr;
   logic [2:0]  outstanding;
   logic        unmatched;

   always #5 clk = ~clk;

   xdma_finish_tracker dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .start_valid_i(start_valid), .start_ready_o(start_ready), .start_is_middle_i(start_is_middle),
      .start_id_i(start_id), .start_addr_i(start_addr),
      .last_done_valid_i(ld_valid), .last_done_ready_o(ld_ready),
      .last_done_id_i(ld_id), .last_done_addr_i(ld_addr),
      .read_done_valid_i(rd_valid), .read_done_ready_o(rd_ready), .read_done_id_i(rd_id),
      .from_remote_finish_valid_i(fr_valid), .from_remote_finish_ready_o(fr_ready),
      .from_remote_finish_id_i(fr_id),
      .xdma_finish_o(xf), .xdma_finish_ready_i(xf_ready), .xdma_finish_id_o(xf_id),
      .xdma_finish_is_read_o(xf_is_read), .xdma_write_finish_o(wf),
      .to_remote_finish_valid_o(tr_valid), .to_remote_finish_ready_i(tr_ready),
      .from_remote_dma_id_o(tr_id), .remote_addr_o(tr_addr),
      .outstanding_o(outstanding), .unmatched_o(unmatched)
   );

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: live hops keyed by id, send queue, one local-finish entry.
   typedef struct { logic [7:0] id; logic [47:0] addr; } send_t;
   bit          live [256];
   bit          lmid [256];
   logic [47:0] laddr[256];
   int          nlive;
   send_t       sendq[$];
   bit          lf_v, lf_rd;
   logic [7:0]  lf_id;
   bit          exp_wf, exp_unm;

   task automatic model_reset();
      foreach (live[i]) live[i] = 0;
      nlive = 0; sendq.delete();
      lf_v = 0; lf_rd = 0; lf_id = 0; exp_wf = 0; exp_unm = 0;
   endtask

   task automatic idle_inputs();
      start_valid = 0; start_is_middle = 0; start_id = 0; start_addr = 0;
      ld_valid = 0; ld_id = 0; ld_addr = 0; rd_valid = 0; rd_id = 0;
      fr_valid = 0; fr_id = 0; xf_ready = 0; tr_ready = 0;
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_start_rdy"}, start_ready, 1);
      chk({pfx, "_ld_rdy"},    ld_ready, 1);
      chk({pfx, "_rd_rdy"},    rd_ready, 1);
      chk({pfx, "_fr_rdy"},    fr_ready, 1);
      chk({pfx, "_outs"}, {xf, xf_id, xf_is_read, wf, tr_valid, tr_id, tr_addr[31:0], outstanding, unmatched}, 0);
      chk({pfx, "_addr_hi"}, tr_addr[47:32], 0);
   endtask

   task automatic step();
      bit sr, fhit, fmid, fr_exp, tfa, tma, rr, lr, pop;
      send_t e;
      @(negedge clk);
      start_valid = $urandom_range(0, 1);
      start_is_middle = $urandom_range(0, 1);
      start_id = 8'($urandom_range(0, 7));
      start_addr = {16'($urandom), 32'($urandom)};
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_id = 8'($urandom_range(100, 200));
      ld_addr = {16'($urandom), 32'($urandom)};
      rd_valid = ($urandom_range(0, 2) == 0);
      rd_id = 8'($urandom_range(0, 255));
      fr_valid = $urandom_range(0, 1);
      fr_id = 8'($urandom_range(0, 8));
      xf_ready = ($urandom_range(0, 2) != 0);
      tr_ready = ($urandom_range(0, 3) == 0);
      #1;
      sr     = (nlive < 4) && !live[start_id];
      fhit   = live[fr_id];
      fmid   = lmid[fr_id];
      fr_exp = !fhit || (fmid ? (sendq.size() < 4) : !lf_v);
      tfa    = fr_valid && fhit && !fmid && !lf_v;
      tma    = fr_valid && fhit && fmid && (sendq.size() < 4);
      rr     = !lf_v && !tfa;
      lr     = (sendq.size() < 4) && !tma;
      pop    = (sendq.size() > 0) && tr_ready;

      chk("start_ready", start_ready, sr);
      chk("fr_ready", fr_ready, fr_exp);
      chk("rd_ready", rd_ready, rr);
      chk("ld_ready", ld_ready, lr);
      chk("xdma_finish", xf, lf_v);
      if (lf_v) chk("xdma_finish_data", {xf_id, xf_is_read}, {lf_id, lf_rd});
      chk("to_remote_valid", tr_valid, sendq.size() > 0);
      if (sendq.size() > 0) chk("to_remote_data", {tr_id, tr_addr}, {sendq[0].id, sendq[0].addr});
      chk("outstanding", outstanding, nlive);
      chk("write_finish", wf, exp_wf);
      chk("unmatched", unmatched, exp_unm);

      exp_wf  = tfa || pop;
      exp_unm = fr_valid && !fhit;
      if (pop) void'(sendq.pop_front());
      if (tma) begin
         e.id = fr_id; e.addr = laddr[fr_id]; sendq.push_back(e);
      end else if (ld_valid && lr) begin
         e.id = ld_id; e.addr = ld_addr; sendq.push_back(e);
      end
      if (lf_v && xf_ready) lf_v = 0;
      if (tfa) begin
         lf_v = 1; lf_id = fr_id; lf_rd = 0;
      end else if (rd_valid && rr) begin
         lf_v = 1; lf_id = rd_id; lf_rd = 1;
      end
      if (tfa || tma) begin
         live[fr_id] = 0; nlive--;
      end
      if (start_valid && sr) begin
         live[start_id] = 1; lmid[start_id] = start_is_middle;
         laddr[start_id] = start_addr; nlive++;
      end
   endtask

   initial begin
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset");
      rst_ni = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            @(negedge clk);
            idle_inputs();
            rst_ni = 0;
            #1;
            chk_reset_state("midreset");
            model_reset();
            @(negedge clk);
            rst_ni = 1;
         end
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
